// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central hazard scheduler for the 5-stage pipeline. It produces:
//  - the per-stage stall vector and the global flush;
//  - the operand forwarding selects for the id stage;
//  - load-use stalls;
//  - multi-cycle MDU sequencing through a busy counter;
//  - the branch delay slot flag.
// stall_o and the forwarding selects are combinational from the inputs and
// the current state. All outputs are forced to 0 while rst is low.

module pipeline_hazard_ctrl #(
    parameter int MDU_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_i,
    input  logic       id_reg1_read_i,
    input  logic [4:0] id_reg1_addr_i,
    input  logic       id_reg2_read_i,
    input  logic [4:0] id_reg2_addr_i,
    input  logic       id_branch_i,
    input  logic       stallreq_id_i,
    input  logic       stallreq_ex_i,
    input  logic       ex_wreg_i,
    input  logic [4:0] ex_wd_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_mdu_start_i,
    input  logic       mem_wreg_i,
    input  logic [4:0] mem_wd_i,
    output logic [5:0] stall_o,
    output logic       flush_o,
    output logic [1:0] reg1_fwd_sel_o,
    output logic [1:0] reg2_fwd_sel_o,
    output logic       mdu_done_o,
    output logic       in_delay_slot_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    // Counter value loaded on an MDU start; the op then holds ex for MDU_LAT cycles.
    localparam logic [2:0] CNT_LOAD = 3'(MDU_LAT - 1);

    localparam logic [5:0] HOLD_THRU_EX = 6'b001111;
    localparam logic [5:0] HOLD_THRU_ID = 6'b000111;

    mdu_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       ds_q, ds_d;

    logic       mdu_stall_s;
    logic       mdu_done_s;
    logic       load_use_s;
    logic [5:0] stall_s;
    logic [1:0] fwd1_s;
    logic [1:0] fwd2_s;

    // Forwarding source for one id operand.
    // ex wins over mem. A load still in ex has no data yet, so it cannot
    // forward from ex.
    function automatic logic [1:0] fwd_sel(
        input logic       rd,
        input logic [4:0] addr,
        input logic       ex_wreg,
        input logic       ex_mem_read,
        input logic [4:0] ex_wd,
        input logic       mem_wreg,
        input logic [4:0] mem_wd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (!rd || addr == 5'd0) begin
            sel = 2'b00;
        end else if (ex_wreg && !ex_mem_read && addr == ex_wd) begin
            sel = 2'b01;
        end else if (mem_wreg && addr == mem_wd) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // MDU busy sequencer: next state, counter, MDU stall term and done pulse.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mdu_stall_s = 1'b0;
        mdu_done_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_mdu_start_i) begin
                    mdu_stall_s = 1'b1;
                    cnt_d       = CNT_LOAD;
                    state_d     = BUSY;
                end else begin
                    cnt_d = 3'd0;
                end
            end
            BUSY: begin
                // ex_mdu_start_i is ignored here: ex still holds the same frozen op.
                if (cnt_q != 3'd0) begin
                    mdu_stall_s = 1'b1;
                    cnt_d       = cnt_q - 3'd1;
                end else begin
                    mdu_done_s = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
        if (flush_i) begin
            state_d     = IDLE;
            cnt_d       = 3'd0;
            mdu_stall_s = 1'b0;
            mdu_done_s  = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // Load-use detection, OR-merged stall vector, forwarding and delay-slot next value.
    always_comb begin
        load_use_s = ex_mem_read_i && ex_wreg_i && (ex_wd_i != 5'd0) &&
                     ((id_reg1_read_i && id_reg1_addr_i == ex_wd_i) ||
                      (id_reg2_read_i && id_reg2_addr_i == ex_wd_i));
        stall_s = 6'b000000;
        if (mdu_stall_s || stallreq_ex_i) begin
            stall_s = stall_s | HOLD_THRU_EX;
        end else begin
            stall_s = stall_s;
        end
        if (load_use_s || stallreq_id_i) begin
            stall_s = stall_s | HOLD_THRU_ID;
        end else begin
            stall_s = stall_s;
        end
        if (flush_i) begin
            stall_s = 6'b000000;
        end else begin
            stall_s = stall_s;
        end
        fwd1_s = fwd_sel(id_reg1_read_i, id_reg1_addr_i, ex_wreg_i, ex_mem_read_i,
                         ex_wd_i, mem_wreg_i, mem_wd_i);
        fwd2_s = fwd_sel(id_reg2_read_i, id_reg2_addr_i, ex_wreg_i, ex_mem_read_i,
                         ex_wd_i, mem_wreg_i, mem_wd_i);
        // The flag only advances when id/ex is not held.
        if (flush_i) begin
            ds_d = 1'b0;
        end else if (!stall_s[2]) begin
            ds_d = id_branch_i;
        end else begin
            ds_d = ds_q;
        end
    end

    // State, counter and delay-slot registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            ds_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ds_q    <= ds_d;
        end
    end

    // Output drive, forced to 0 for as long as reset is asserted.
    always_comb begin
        if (!rst) begin
            stall_o         = 6'b000000;
            flush_o         = 1'b0;
            reg1_fwd_sel_o  = 2'b00;
            reg2_fwd_sel_o  = 2'b00;
            mdu_done_o      = 1'b0;
            in_delay_slot_o = 1'b0;
        end else begin
            stall_o         = stall_s;
            flush_o         = flush_i;
            reg1_fwd_sel_o  = fwd1_s;
            reg2_fwd_sel_o  = fwd2_s;
            mdu_done_o      = mdu_done_s;
            in_delay_slot_o = ds_q;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl.
// The first part is a set of directed scenarios checked against constants.
// The second part is a randomized run checked against a cycle-timeline model:
// an MDU op is tracked by its start cycle, not by a counter.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

    localparam int MDU_LAT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush_i = 1'b0;
    logic       id_reg1_read_i = 1'b0;
    logic [4:0] id_reg1_addr_i = 5'd0;
    logic       id_reg2_read_i = 1'b0;
    logic [4:0] id_reg2_addr_i = 5'd0;
    logic       id_branch_i = 1'b0;
    logic       stallreq_id_i = 1'b0;
    logic       stallreq_ex_i = 1'b0;
    logic       ex_wreg_i = 1'b0;
    logic [4:0] ex_wd_i = 5'd0;
    logic       ex_mem_read_i = 1'b0;
    logic       ex_mdu_start_i = 1'b0;
    logic       mem_wreg_i = 1'b0;
    logic [4:0] mem_wd_i = 5'd0;
    logic [5:0] stall_o;
    logic       flush_o;
    logic [1:0] reg1_fwd_sel_o;
    logic [1:0] reg2_fwd_sel_o;
    logic       mdu_done_o;
    logic       in_delay_slot_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: MDU activity as (active, start cycle), plus the delay-slot flag.
    int cyc = 0;
    bit m_act = 1'b0;
    int m_t0 = 0;
    bit m_ds = 1'b0;
    logic [5:0] exp_stall;
    logic       exp_done;

    pipeline_hazard_ctrl #(.MDU_LAT(MDU_LAT)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .id_reg1_read_i(id_reg1_read_i), .id_reg1_addr_i(id_reg1_addr_i),
        .id_reg2_read_i(id_reg2_read_i), .id_reg2_addr_i(id_reg2_addr_i),
        .id_branch_i(id_branch_i), .stallreq_id_i(stallreq_id_i),
        .stallreq_ex_i(stallreq_ex_i), .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i),
        .ex_mem_read_i(ex_mem_read_i), .ex_mdu_start_i(ex_mdu_start_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i),
        .stall_o(stall_o), .flush_o(flush_o),
        .reg1_fwd_sel_o(reg1_fwd_sel_o), .reg2_fwd_sel_o(reg2_fwd_sel_o),
        .mdu_done_o(mdu_done_o), .in_delay_slot_o(in_delay_slot_o)
    );

    // 10 ns clock, rising edges at 5, 15, ...
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic rd, input logic [4:0] a);
        if (!rd || a == 5'd0) return 2'b00;
        if (ex_wreg_i && !ex_mem_read_i && a == ex_wd_i) return 2'b01;
        if (mem_wreg_i && a == mem_wd_i) return 2'b10;
        return 2'b00;
    endfunction

    // Compare every output against the model, for the inputs currently applied.
    task automatic model_check(input string tag);
        bit mstall;
        bit lu;
        mstall = 1'b0;
        exp_done = 1'b0;
        if (m_act) begin
            if (cyc - m_t0 < MDU_LAT) mstall = 1'b1;
            else exp_done = 1'b1;
        end else if (ex_mdu_start_i) begin
            mstall = 1'b1;
        end
        lu = ex_mem_read_i && ex_wreg_i && ex_wd_i != 5'd0 &&
             ((id_reg1_read_i && id_reg1_addr_i == ex_wd_i) ||
              (id_reg2_read_i && id_reg2_addr_i == ex_wd_i));
        exp_stall = 6'b000000;
        if (mstall || stallreq_ex_i) exp_stall |= 6'b001111;
        if (lu || stallreq_id_i) exp_stall |= 6'b000111;
        if (flush_i) begin
            exp_stall = 6'b000000;
            exp_done  = 1'b0;
        end
        chk({tag, "_stall"}, stall_o, exp_stall);
        chk({tag, "_flush"}, {5'd0, flush_o}, {5'd0, flush_i});
        chk({tag, "_fwd1"}, {4'd0, reg1_fwd_sel_o}, {4'd0, m_fwd(id_reg1_read_i, id_reg1_addr_i)});
        chk({tag, "_fwd2"}, {4'd0, reg2_fwd_sel_o}, {4'd0, m_fwd(id_reg2_read_i, id_reg2_addr_i)});
        chk({tag, "_done"}, {5'd0, mdu_done_o}, {5'd0, exp_done});
        chk({tag, "_ds"}, {5'd0, in_delay_slot_o}, {5'd0, m_ds});
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_commit();
        if (flush_i) begin
            m_act = 1'b0;
            m_ds  = 1'b0;
        end else begin
            if (m_act && cyc - m_t0 >= MDU_LAT) m_act = 1'b0;
            else if (!m_act && ex_mdu_start_i) begin
                m_act = 1'b1;
                m_t0  = cyc;
            end
            if (!exp_stall[2]) m_ds = id_branch_i;
        end
        cyc++;
    endtask

    task automatic at_neg(input string tag);
        @(negedge clk);
        model_check(tag);
    endtask

    task automatic edge_adv();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i = 1'b0; id_reg1_read_i = 1'b0; id_reg1_addr_i = 5'd0;
        id_reg2_read_i = 1'b0; id_reg2_addr_i = 5'd0; id_branch_i = 1'b0;
        stallreq_id_i = 1'b0; stallreq_ex_i = 1'b0; ex_wreg_i = 1'b0; ex_wd_i = 5'd0;
        ex_mem_read_i = 1'b0; ex_mdu_start_i = 1'b0; mem_wreg_i = 1'b0; mem_wd_i = 5'd0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_stall"}, stall_o, 6'b000000);
        chk({tag, "_misc"}, {flush_o, reg1_fwd_sel_o, reg2_fwd_sel_o, mdu_done_o},
            6'b000000);
        chk({tag, "_ds"}, {5'd0, in_delay_slot_o}, 6'd0);
    endtask

    initial begin
        // Reset with busy-looking inputs: every output must stay 0.
        stallreq_ex_i = 1'b1; flush_i = 1'b1; ex_mdu_start_i = 1'b1;
        id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd3; ex_wreg_i = 1'b1; ex_wd_i = 5'd3;
        id_branch_i = 1'b1;
        @(negedge clk); all_zero("rst_a");
        @(negedge clk); all_zero("rst_b");
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        m_act = 1'b0; m_ds = 1'b0;
        at_neg("idle"); chk("idle_stall_c", stall_o, 6'b000000);
        edge_adv();

        // Load-use: ex lw $5, id reads $5 on reg1.
        ex_mem_read_i = 1'b1; ex_wreg_i = 1'b1; ex_wd_i = 5'd5;
        id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd5;
        at_neg("lu"); chk("lu_stall_c", stall_o, 6'b000111);
        edge_adv();
        ex_mem_read_i = 1'b0; ex_wreg_i = 1'b0; ex_wd_i = 5'd0;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd5;
        at_neg("lu2"); chk("lu2_fwd_c", {4'd0, reg1_fwd_sel_o}, 6'd2);
        chk("lu2_stall_c", stall_o, 6'b000000);
        edge_adv();

        // ex/mem both write $3: ex wins on both operands; $0 never forwards.
        idle_inputs();
        ex_wreg_i = 1'b1; ex_wd_i = 5'd3; mem_wreg_i = 1'b1; mem_wd_i = 5'd3;
        id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd3;
        id_reg2_read_i = 1'b1; id_reg2_addr_i = 5'd3;
        at_neg("fw"); chk("fw_c", {reg1_fwd_sel_o, reg2_fwd_sel_o}, 6'b000101);
        edge_adv();
        ex_wd_i = 5'd0; mem_wd_i = 5'd0; id_reg1_addr_i = 5'd0; id_reg2_addr_i = 5'd0;
        at_neg("fw0"); chk("fw0_c", {reg1_fwd_sel_o, reg2_fwd_sel_o}, 6'b000000);
        edge_adv();

        // MDU: stalled for MDU_LAT cycles, then a single done pulse.
        idle_inputs();
        ex_mdu_start_i = 1'b1;
        for (int k = 0; k < MDU_LAT; k++) begin
            at_neg("mdu"); chk("mdu_stall_c", stall_o, 6'b001111);
            chk("mdu_nodone_c", {5'd0, mdu_done_o}, 6'd0);
            edge_adv();
        end
        at_neg("mdu_end"); chk("mdu_done_c", {5'd0, mdu_done_o}, 6'd1);
        chk("mdu_rel_c", stall_o, 6'b000000);
        edge_adv();
        ex_mdu_start_i = 1'b0;
        at_neg("mdu_after"); chk("mdu_after_c", {5'd0, mdu_done_o}, 6'd0);
        edge_adv();

        // Delay slot: set when unstalled, held through a stall, then follows the branch input.
        id_branch_i = 1'b1;
        at_neg("ds0"); edge_adv();
        id_branch_i = 1'b0; stallreq_id_i = 1'b1;
        at_neg("ds1"); chk("ds_set_c", {5'd0, in_delay_slot_o}, 6'd1);
        edge_adv();
        stallreq_id_i = 1'b0;
        at_neg("ds2"); chk("ds_hold_c", {5'd0, in_delay_slot_o}, 6'd1);
        edge_adv();
        at_neg("ds3"); chk("ds_clr_c", {5'd0, in_delay_slot_o}, 6'd0);
        edge_adv();

        // Flush in the third MDU cycle (counter at 2): no done pulse afterwards.
        ex_mdu_start_i = 1'b1;
        at_neg("fl0"); edge_adv();
        at_neg("fl1"); edge_adv();
        flush_i = 1'b1;
        at_neg("fl2"); chk("fl_flush_c", {5'd0, flush_o}, 6'd1);
        chk("fl_stall_c", stall_o, 6'b000000);
        edge_adv();
        flush_i = 1'b0; ex_mdu_start_i = 1'b0;
        for (int k = 0; k < MDU_LAT; k++) begin
            at_neg("fl_post"); chk("fl_nodone_c", {5'd0, mdu_done_o}, 6'd0);
            chk("fl_nostall_c", stall_o, 6'b000000);
            edge_adv();
        end

        // Asynchronous reset in the middle of an MDU op, between clock edges.
        ex_mdu_start_i = 1'b1; id_branch_i = 1'b1;
        at_neg("ar0"); edge_adv();
        at_neg("ar1"); edge_adv();
        #2 rst = 1'b0;
        #1 all_zero("arst");
        @(posedge clk); #1;
        rst = 1'b1; idle_inputs();
        m_act = 1'b0; m_ds = 1'b0;
        for (int k = 0; k < MDU_LAT + 1; k++) begin
            at_neg("ar_post"); chk("ar_nostall_c", stall_o, 6'b000000);
            edge_adv();
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            flush_i        = ($urandom_range(0, 19) == 0);
            id_reg1_read_i = $urandom_range(0, 1);
            id_reg1_addr_i = 5'($urandom_range(0, 3));
            id_reg2_read_i = $urandom_range(0, 1);
            id_reg2_addr_i = 5'($urandom_range(0, 3));
            id_branch_i    = $urandom_range(0, 1);
            stallreq_id_i  = ($urandom_range(0, 9) == 0);
            stallreq_ex_i  = ($urandom_range(0, 14) == 0);
            ex_wreg_i      = $urandom_range(0, 1);
            ex_wd_i        = 5'($urandom_range(0, 3));
            ex_mem_read_i  = ($urandom_range(0, 3) == 0);
            ex_mdu_start_i = ($urandom_range(0, 7) == 0);
            mem_wreg_i     = $urandom_range(0, 1);
            mem_wd_i       = 5'($urandom_range(0, 3));
            at_neg("rnd");
            edge_adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
